pe_arbiter: RTL

PE_ARBITER -- requirements
Module: pe_arbiter

---
 rtl/pe_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/pe_arbiter.sv
// pe_arbiter: round-robin sharing of one pipelined integer PE among NREQ requesters; grant counters enabled by PE_ARB_PERF_EN
module pe_arbiter #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 6,
  parameter int DW      = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*DW-1:0]         req_inp1,
  input  logic [NREQ*DW-1:0]         req_inp2,
  input  logic [NREQ*2-1:0]          req_op,
  output logic [DW-1:0]              pe_inp1,
  output logic [DW-1:0]              pe_inp2,
  output logic [1:0]                 pe_op,
  output logic                       pe_valid,
  input  logic [DW-1:0]              pe_out1,
  input  logic                       pe_valid_out,
  output logic                       rsp_valid,
  output logic [DW-1:0]              rsp_data,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic                       err_tag,
  output logic [NREQ*16-1:0]         perf_cnt
);
  localparam int IW = $clog2(NREQ);
  localparam int QW = $clog2(LATENCY + 1);
  logic [IW-1:0] ptr, win, idx, pe_id;
  logic          any, grant, head_valid;
  logic [IW:0]   tag [LATENCY];
  logic [QW-1:0] quiet;
  // scan offsets far-to-near so the requester closest to ptr is the last to overwrite win
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (req_valid[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end
  assign grant     = rst & en & any;
  assign req_ready = grant ? NREQ'(1) << win : '0;
  // issue register: capture the winner's operation, hold operands while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      pe_valid <= 1'b0;
      pe_inp1  <= '0;
      pe_inp2  <= '0;
      pe_op    <= '0;
      pe_id    <= '0;
    end else begin
      pe_valid <= grant;
      if (grant) begin
        ptr     <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
        pe_inp1 <= req_inp1[win*DW +: DW];
        pe_inp2 <= req_inp2[win*DW +: DW];
        pe_op   <= req_op[win*2 +: 2];
        pe_id   <= win;
      end
    end
  end
  // tag pipe follows pe_valid so its head lines up with the PE result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < LATENCY; k++) tag[k] <= '0;
    end else begin
      tag[0] <= {pe_valid, pe_id};
      for (int k = 1; k < LATENCY; k++) tag[k] <= tag[k-1];
    end
  end
  assign head_valid = tag[LATENCY-1][IW];
  // sticky mismatch flag, muted while results of ops issued before reset may still drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quiet   <= QW'(LATENCY);
      err_tag <= 1'b0;
    end else begin
      if (quiet != '0) quiet <= quiet - 1'b1;
      if (quiet == '0 && pe_valid_out != head_valid) err_tag <= 1'b1;
    end
  end
  assign rsp_valid = rst & pe_valid_out & head_valid;
  assign rsp_data  = pe_out1;
  assign rsp_id    = tag[LATENCY-1][IW-1:0];
`ifdef PE_ARB_PERF_EN
  for (genvar g = 0; g < NREQ; g++) begin : g_perf
    logic [15:0] cnt;
    // saturating count of grants to requester g
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt <= '0;
      else if (grant && win == IW'(g) && cnt != 16'hFFFF) cnt <= cnt + 1'b1;
    end
    assign perf_cnt[g*16 +: 16] = cnt;
  end
`else
  assign perf_cnt = '0;
`endif
endmodule
